// File: rtl/ecc_secded_pipe_decoder.sv
// ecc_secded_pipe_decoder
// Two-stage Hamming SEC/DED decoder with a valid/ready handshake, saturating
// SBE/MBE counters, a first-error log and threshold fault outputs.
// Optional feature macro: ECC_ERR_INJECT_EN adds inj_mask_in, XORed onto
// {ecc_in, data_in} for accepted words before decoding.
module ecc_secded_pipe_decoder #(
   parameter int DATA_WIDTH    = 64,
   parameter int ECC_WIDTH     = 8,
   parameter int ADDR_WIDTH    = 32,
   parameter int CNT_WIDTH     = 16,
   parameter int SBE_THRESHOLD = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_WIDTH-1:0]           data_in,
   input  logic [ECC_WIDTH-1:0]            ecc_in,
   input  logic [ADDR_WIDTH-1:0]           addr_in,
`ifdef ECC_ERR_INJECT_EN
   input  logic [DATA_WIDTH+ECC_WIDTH-1:0] inj_mask_in,
`endif
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-1:0]           data_out,
   output logic [ADDR_WIDTH-1:0]           addr_out,
   output logic                            sbe_flag,
   output logic                            mbe_flag,
   output logic [ECC_WIDTH-2:0]            syndrome_out,
   output logic [CNT_WIDTH-1:0]            sbe_count,
   output logic [CNT_WIDTH-1:0]            mbe_count,
   input  logic                            cnt_clr,
   output logic                            log_valid,
   output logic [ADDR_WIDTH-1:0]           log_addr,
   output logic [ECC_WIDTH-2:0]            log_syndrome,
   output logic                            log_is_mbe,
   input  logic                            log_clr,
   output logic                            fault_sbe_thresh,
   output logic                            fault_mbe
);

   localparam int     SW         = ECC_WIDTH - 1;
   localparam int     NPOS       = DATA_WIDTH + ECC_WIDTH - 1;
   localparam longint CNT_MAX    = (longint'(1) << CNT_WIDTH) - 1;
   // A saturated counter can never exceed CNT_MAX, so a larger threshold is met at saturation.
   localparam longint THRESH_EFF = (longint'(SBE_THRESHOLD) > CNT_MAX) ? CNT_MAX : longint'(SBE_THRESHOLD);

   generate
      if (!((DATA_WIDTH == 32 && ECC_WIDTH == 7) || (DATA_WIDTH == 64 && ECC_WIDTH == 8) ||
            (DATA_WIDTH == 128 && ECC_WIDTH == 9))) begin : gBadWidths
         $error("ecc_secded_pipe_decoder: DATA_WIDTH/ECC_WIDTH must be 32/7, 64/8 or 128/9");
      end
      if (SBE_THRESHOLD < 1) begin : gBadThresh
         $error("ecc_secded_pipe_decoder: SBE_THRESHOLD must be at least 1");
      end
   endgenerate

   function automatic logic isPow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   logic                  adv, accept, fire;
   logic [DATA_WIDTH-1:0] dataRx;
   logic [ECC_WIDTH-1:0]  eccRx;

   logic                  s1Valid_q, s1Par_q, s1Par_d;
   logic [SW-1:0]         s1Syn_q, s1Syn_d;
   logic [DATA_WIDTH-1:0] s1Data_q;
   logic [ADDR_WIDTH-1:0] s1Addr_q;

   logic                  outValid_q;
   logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
   logic [ADDR_WIDTH-1:0] addrOut_q;
   logic                  sbeFlag_q, sbeFlag_d, mbeFlag_q, mbeFlag_d;
   logic [SW-1:0]         synOut_q;

   logic [CNT_WIDTH-1:0]  sbeCount_q, sbeCount_d, mbeCount_q, mbeCount_d;
   logic                  logValid_q, logValid_d, logIsMbe_q, logIsMbe_d;
   logic [ADDR_WIDTH-1:0] logAddr_q, logAddr_d;
   logic [SW-1:0]         logSyn_q, logSyn_d;

   // Both stages move together; nothing moves while a word waits at the output.
   assign adv      = !outValid_q | out_ready;
   assign in_ready = adv & ~rst;
   assign accept   = in_valid & in_ready;
   assign fire     = outValid_q & out_ready;

`ifdef ECC_ERR_INJECT_EN
   assign {eccRx, dataRx} = {ecc_in, data_in} ^ (accept ? inj_mask_in : '0);
`else
   assign {eccRx, dataRx} = {ecc_in, data_in};
`endif

   // Stage 1 decode: walk the codeword positions, XOR in the position of every set bit.
   always_comb begin
      int   di;
      int   ci;
      logic cwBit;
      s1Syn_d = '0;
      di      = 0;
      ci      = 0;
      cwBit   = 1'b0;
      for (int p = 1; p <= NPOS; p++) begin
         if (isPow2(p)) begin
            cwBit = eccRx[ci];
            ci++;
         end else begin
            cwBit = dataRx[di];
            di++;
         end
         if (cwBit) s1Syn_d = s1Syn_d ^ SW'(p);
      end
      s1Par_d = ^{eccRx, dataRx};
   end

   // Stage 2 classification and correction; a check-bit or parity-bit error leaves data alone.
   always_comb begin
      int   di;
      logic isErr;
      logic isSbe;
      isErr     = (s1Syn_q != '0) | s1Par_q;
      isSbe     = s1Par_q & (32'(s1Syn_q) <= 32'(NPOS));
      dataOut_d = s1Data_q;
      di        = 0;
      for (int p = 1; p <= NPOS; p++) begin
         if (!isPow2(p)) begin
            if (isSbe && (s1Syn_q == SW'(p))) dataOut_d[di] = ~s1Data_q[di];
            di++;
         end
      end
      sbeFlag_d = s1Valid_q & isSbe;
      mbeFlag_d = s1Valid_q & isErr & ~isSbe;
   end

   // Pipeline registers for both stages; reset discards any words in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_q  <= 1'b0;
         s1Syn_q    <= '0;
         s1Par_q    <= 1'b0;
         s1Data_q   <= '0;
         s1Addr_q   <= '0;
         outValid_q <= 1'b0;
         dataOut_q  <= '0;
         addrOut_q  <= '0;
         sbeFlag_q  <= 1'b0;
         mbeFlag_q  <= 1'b0;
         synOut_q   <= '0;
      end else if (adv) begin
         s1Valid_q  <= accept;
         s1Syn_q    <= s1Syn_d;
         s1Par_q    <= s1Par_d;
         s1Data_q   <= dataRx;
         s1Addr_q   <= addr_in;
         outValid_q <= s1Valid_q;
         dataOut_q  <= dataOut_d;
         addrOut_q  <= s1Addr_q;
         sbeFlag_q  <= sbeFlag_d;
         mbeFlag_q  <= mbeFlag_d;
         synOut_q   <= s1Syn_q;
      end
   end

   // Event counters count each delivered word once and stick at all-ones.
   always_comb begin
      sbeCount_d = sbeCount_q;
      mbeCount_d = mbeCount_q;
      if (cnt_clr) begin
         sbeCount_d = CNT_WIDTH'(fire & sbeFlag_q);
         mbeCount_d = CNT_WIDTH'(fire & mbeFlag_q);
      end else begin
         if (fire && sbeFlag_q && (sbeCount_q != '1)) sbeCount_d = sbeCount_q + CNT_WIDTH'(1);
         if (fire && mbeFlag_q && (mbeCount_q != '1)) mbeCount_d = mbeCount_q + CNT_WIDTH'(1);
      end
   end

   // Error log keeps the first error, lets an MBE replace an SBE, and a new error wins over a clear.
   always_comb begin
      logic err;
      logic take;
      err        = fire & (sbeFlag_q | mbeFlag_q);
      take       = err & (log_clr | ~logValid_q | (mbeFlag_q & ~logIsMbe_q));
      logValid_d = logValid_q;
      logAddr_d  = logAddr_q;
      logSyn_d   = logSyn_q;
      logIsMbe_d = logIsMbe_q;
      if (take) begin
         logValid_d = 1'b1;
         logAddr_d  = addrOut_q;
         logSyn_d   = synOut_q;
         logIsMbe_d = mbeFlag_q;
      end else if (log_clr) begin
         logValid_d = 1'b0;
         logAddr_d  = '0;
         logSyn_d   = '0;
         logIsMbe_d = 1'b0;
      end
   end

   // Counter and log state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbeCount_q <= '0;
         mbeCount_q <= '0;
         logValid_q <= 1'b0;
         logAddr_q  <= '0;
         logSyn_q   <= '0;
         logIsMbe_q <= 1'b0;
      end else begin
         sbeCount_q <= sbeCount_d;
         mbeCount_q <= mbeCount_d;
         logValid_q <= logValid_d;
         logAddr_q  <= logAddr_d;
         logSyn_q   <= logSyn_d;
         logIsMbe_q <= logIsMbe_d;
      end
   end

   assign out_valid        = outValid_q;
   assign data_out         = dataOut_q;
   assign addr_out         = addrOut_q;
   assign sbe_flag         = sbeFlag_q;
   assign mbe_flag         = mbeFlag_q;
   assign syndrome_out     = synOut_q;
   assign sbe_count        = sbeCount_q;
   assign mbe_count        = mbeCount_q;
   assign log_valid        = logValid_q;
   assign log_addr         = logAddr_q;
   assign log_syndrome     = logSyn_q;
   assign log_is_mbe       = logIsMbe_q;
   assign fault_sbe_thresh = (64'(sbeCount_q) >= 64'(THRESH_EFF));
   assign fault_mbe        = (mbeCount_q != '0);

endmodule

// File: tb/tb_ecc_secded_pipe_decoder.sv
// Testbench for ecc_secded_pipe_decoder (64-bit data, 4-bit counters, threshold 16).
module tb_ecc_secded_pipe_decoder;

   localparam int DW      = 64;
   localparam int EW      = 8;
   localparam int AW      = 32;
   localparam int CW      = 4;
   localparam int TH      = 16;
   localparam int NPOS    = DW + EW - 1;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int TH_EFF  = (TH > CNT_MAX) ? CNT_MAX : TH;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
      logic          sbe;
      logic          mbe;
      logic [EW-2:0] syn;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] data_in, data_out;
   logic [EW-1:0] ecc_in;
   logic [AW-1:0] addr_in, addr_out, log_addr;
   logic          sbe_flag, mbe_flag, log_valid, log_is_mbe;
   logic [EW-2:0] syndrome_out, log_syndrome;
   logic [CW-1:0] sbe_count, mbe_count;
   logic          cnt_clr, log_clr, fault_sbe_thresh, fault_mbe;
`ifdef ECC_ERR_INJECT_EN
   logic [DW+EW-1:0] inj_mask_in;
`endif

   int   testsRun    = 0;
   int   testsFailed = 0;
   exp_t expQ[$];
   int   mSbe, mMbe;
   logic mLogValid, mLogMbe;
   logic [AW-1:0] mLogAddr;
   logic [EW-2:0] mLogSyn;

   always #5 clk = ~clk;

   ecc_secded_pipe_decoder #(
      .DATA_WIDTH(DW), .ECC_WIDTH(EW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .SBE_THRESHOLD(TH)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .ecc_in(ecc_in), .addr_in(addr_in),
`ifdef ECC_ERR_INJECT_EN
      .inj_mask_in(inj_mask_in),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .addr_out(addr_out),
      .sbe_flag(sbe_flag), .mbe_flag(mbe_flag), .syndrome_out(syndrome_out),
      .sbe_count(sbe_count), .mbe_count(mbe_count), .cnt_clr(cnt_clr),
      .log_valid(log_valid), .log_addr(log_addr), .log_syndrome(log_syndrome),
      .log_is_mbe(log_is_mbe), .log_clr(log_clr),
      .fault_sbe_thresh(fault_sbe_thresh), .fault_mbe(fault_mbe)
   );

   // Codeword position of data bit i: the (i+1)-th position that is not a power of two.
   function automatic int dataPos(input int i);
      int pos;
      int k;
      pos = i + 1;
      k   = 0;
      while ((1 << k) <= pos) begin
         pos++;
         k++;
      end
      return pos;
   endfunction

   function automatic logic [EW-1:0] encode(input logic [DW-1:0] d);
      int s;
      logic [EW-1:0] e;
      s = 0;
      for (int i = 0; i < DW; i++) if (d[i]) s = s ^ dataPos(i);
      e[EW-2:0] = s[EW-2:0];
      e[EW-1]   = ^d ^ ^s[EW-2:0];
      return e;
   endfunction

   // Reference decoder: syndrome from positions, parity over everything, then the classification rules.
   function automatic exp_t refDecode(input logic [DW-1:0] d, input logic [EW-1:0] e, input logic [AW-1:0] a);
      exp_t r;
      int   s;
      int   lg;
      logic p;
      s = 0;
      for (int i = 0; i < DW; i++) if (d[i]) s = s ^ dataPos(i);
      for (int k = 0; k < EW - 1; k++) if (e[k]) s = s ^ (1 << k);
      p      = ^d ^ ^e;
      r.data = d;
      r.addr = a;
      r.syn  = s[EW-2:0];
      r.sbe  = 1'b0;
      r.mbe  = 1'b0;
      if (p) begin
         if (s > NPOS) r.mbe = 1'b1;
         else begin
            r.sbe = 1'b1;
            if (s != 0 && (s & (s - 1)) != 0) begin
               lg = 0;
               while ((2 << lg) <= s) lg++;
               r.data[s - lg - 2] = ~r.data[s - lg - 2];
            end
         end
      end else if (s != 0) r.mbe = 1'b1;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkState();
      checkOutput("sbe_count", 64'(sbe_count), 64'(mSbe));
      checkOutput("mbe_count", 64'(mbe_count), 64'(mMbe));
      checkOutput("fault_sbe_thresh", 64'(fault_sbe_thresh), 64'(mSbe >= TH_EFF));
      checkOutput("fault_mbe", 64'(fault_mbe), 64'(mMbe != 0));
      checkOutput("log_valid", 64'(log_valid), 64'(mLogValid));
      if (mLogValid) begin
         checkOutput("log_addr", 64'(log_addr), 64'(mLogAddr));
         checkOutput("log_syndrome", 64'(log_syndrome), 64'(mLogSyn));
         checkOutput("log_is_mbe", 64'(log_is_mbe), 64'(mLogMbe));
      end
   endtask

   // One clock of stimulus: drive, observe handshakes, update model, advance, check state.
   task automatic applyStimulus(input logic inV, input logic [DW-1:0] d, input logic [EW-1:0] e,
                                input logic [AW-1:0] a, input logic [DW+EW-1:0] mask, input logic oR,
                                input logic cClr, input logic lClr, output logic accepted, output logic readySeen);
      logic fire;
      exp_t h;
      logic [DW+EW-1:0] cw;
      in_valid  = inV;
      data_in   = d;
      ecc_in    = e;
      addr_in   = a;
      out_ready = oR;
      cnt_clr   = cClr;
      log_clr   = lClr;
`ifdef ECC_ERR_INJECT_EN
      inj_mask_in = mask;
      cw = {e, d} ^ mask;
`else
      cw = {e, d};
`endif
      #1;
      readySeen = in_ready;
      accepted  = in_valid && in_ready;
      fire      = out_valid && out_ready;
      h         = '0;
      if (out_valid) begin
         checkOutput("out_has_expected_word", 64'(expQ.size() > 0), 64'd1);
         if (expQ.size() > 0) begin
            h = expQ[0];
            checkOutput("data_out", data_out, h.data);
            checkOutput("addr_out", 64'(addr_out), 64'(h.addr));
            checkOutput("sbe_flag", 64'(sbe_flag), 64'(h.sbe));
            checkOutput("mbe_flag", 64'(mbe_flag), 64'(h.mbe));
            checkOutput("syndrome_out", 64'(syndrome_out), 64'(h.syn));
            if (fire) void'(expQ.pop_front());
         end
      end
      if (cClr) begin
         mSbe = (fire && h.sbe) ? 1 : 0;
         mMbe = (fire && h.mbe) ? 1 : 0;
      end else begin
         if (fire && h.sbe && mSbe < CNT_MAX) mSbe++;
         if (fire && h.mbe && mMbe < CNT_MAX) mMbe++;
      end
      if (fire && (h.sbe || h.mbe) && (lClr || !mLogValid || (h.mbe && !mLogMbe))) begin
         mLogValid = 1'b1;
         mLogAddr  = h.addr;
         mLogSyn   = h.syn;
         mLogMbe   = h.mbe;
      end else if (lClr) begin
         mLogValid = 1'b0;
         mLogMbe   = 1'b0;
      end
      if (accepted) expQ.push_back(refDecode(cw[DW-1:0], cw[DW+EW-1:DW], a));
      @(posedge clk);
      #1;
      checkState();
   endtask

   task automatic idle(input logic oR, input logic cClr, input logic lClr);
      logic acc, rdy;
      applyStimulus(1'b0, '0, '0, '0, '0, oR, cClr, lClr, acc, rdy);
   endtask

   task automatic sendWord(input logic [DW-1:0] d, input logic [EW-1:0] e, input logic [AW-1:0] a);
      logic acc, rdy;
      applyStimulus(1'b1, d, e, a, '0, 1'b1, 1'b0, 1'b0, acc, rdy);
      checkOutput("send_accepted", 64'(acc), 64'd1);
   endtask

   // kind 0: clean, 1..3: that many distinct bit flips across the 72-bit codeword.
   task automatic makeWord(input int kind, output logic [DW-1:0] d, output logic [EW-1:0] e);
      logic [DW+EW-1:0] cw;
      int b1, b2, b3, r1;
      d  = {$urandom(), $urandom()};
      e  = encode(d);
      cw = {e, d};
      b1 = $urandom_range(0, DW + EW - 1);
      r1 = $urandom_range(1, 35);
      b2 = (b1 + r1) % (DW + EW);
      b3 = (b1 + r1 + $urandom_range(1, 35)) % (DW + EW);
      if (kind >= 1) cw[b1] = ~cw[b1];
      if (kind >= 2) cw[b2] = ~cw[b2];
      if (kind >= 3) cw[b3] = ~cw[b3];
      {e, d} = cw;
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && (expQ.size() > 0); i++) idle(1'b1, 1'b0, 1'b0);
      checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
      checkOutput("drain_no_extra_out", 64'(out_valid), 64'd0);
   endtask

   task automatic resetModel();
      expQ.delete();
      mSbe      = 0;
      mMbe      = 0;
      mLogValid = 1'b0;
      mLogMbe   = 1'b0;
      mLogAddr  = '0;
      mLogSyn   = '0;
   endtask

   initial begin
      logic [DW-1:0] d0, d;
      logic [EW-1:0] e0, e;
      logic acc, rdy;
      int idx, cyc;

      resetModel();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; log_clr = 1'b0;
      data_in = '0; ecc_in = '0; addr_in = '0;
`ifdef ECC_ERR_INJECT_EN
      inj_mask_in = '0;
`endif
      #1;
      checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkState();
      rst = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

      // Clean word, two-cycle latency.
      d0 = 64'h0123_4567_89AB_CDEF;
      e0 = encode(d0);
      sendWord(d0, e0, 32'h100);
      checkOutput("lat_after_1", 64'(out_valid), 64'd0);
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("lat_after_2", 64'(out_valid), 64'd1);
      checkOutput("clean_data", data_out, d0);
      checkOutput("clean_flags", 64'({sbe_flag, mbe_flag}), 64'd0);
      idle(1'b1, 1'b0, 1'b0);

      // Single data-bit error at data_in[10] (position 15).
      sendWord(d0 ^ (64'd1 << 10), e0, 32'h200);
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("sbe_flag_direct", 64'(sbe_flag), 64'd1);
      checkOutput("sbe_syndrome_15", 64'(syndrome_out), 64'd15);
      checkOutput("sbe_corrected", data_out, d0);
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("sbe_count_1", 64'(sbe_count), 64'd1);
      checkOutput("log_addr_200", 64'(log_addr), 64'h200);
      checkOutput("log_sbe_kind", 64'(log_is_mbe), 64'd0);

      // Double error at data_in[0] and data_in[5] overwrites the SBE log entry.
      sendWord(d0 ^ 64'h21, e0, 32'h300);
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("mbe_flag_direct", 64'(mbe_flag), 64'd1);
      checkOutput("mbe_data_raw", data_out, d0 ^ 64'h21);
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("fault_mbe_direct", 64'(fault_mbe), 64'd1);
      checkOutput("log_mbe_kind", 64'(log_is_mbe), 64'd1);
      checkOutput("log_addr_300", 64'(log_addr), 64'h300);

      // Odd error count with syndrome 78, beyond the last position: MBE, log untouched.
      sendWord(d0 ^ 64'h18, e0 ^ 8'h40, 32'h400);
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("beyond_last_mbe", 64'(mbe_flag), 64'd1);
      checkOutput("beyond_last_data", data_out, d0 ^ 64'h18);
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("held_mbe_kept", 64'(log_addr), 64'h300);

      // Four words with a three-cycle output stall in the middle.
      idx = 0;
      for (cyc = 0; cyc < 20 && idx < 4; cyc++) begin
         d = d0 + 64'(idx * 7);
         applyStimulus(1'b1, d, encode(d) ^ 8'(idx == 2), 32'h500 + 32'(idx), '0,
                       !(cyc >= 2 && cyc <= 4), 1'b0, 1'b0, acc, rdy);
         if (cyc >= 2 && cyc <= 4) checkOutput("stall_in_ready", 64'(rdy), 64'd0);
         if (acc) idx++;
      end
      checkOutput("stall_all_sent", 64'(idx), 64'd4);
      drain();

      // Randomized stream with random backpressure, bubbles and clears.
      for (int i = 0; i < 60; i++) begin
         makeWord($urandom_range(0, 3), d, e);
         applyStimulus($urandom_range(0, 3) != 0, d, e, $urandom(), '0, $urandom_range(0, 4) != 0,
                       $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, acc, rdy);
      end
      drain();

      // Saturation of the SBE counter and threshold fault.
      idle(1'b1, 1'b1, 1'b0);
      checkOutput("cnt_clr_zero", 64'(sbe_count), 64'd0);
      for (int i = 0; i < 20; i++) begin
         makeWord(1, d, e);
         sendWord(d, e, 32'h1000 + 32'(i));
      end
      drain();
      checkOutput("sbe_saturated", 64'(sbe_count), 64'd15);
      checkOutput("thresh_fault", 64'(fault_sbe_thresh), 64'd1);

      // cnt_clr coincident with a counted SBE leaves a count of one.
      makeWord(1, d, e);
      sendWord(d, e, 32'h2000);
      idle(1'b1, 1'b0, 1'b0);
      idle(1'b1, 1'b1, 1'b0);
      checkOutput("clr_with_sbe", 64'(sbe_count), 64'd1);
      checkOutput("clr_mbe_zero", 64'(mbe_count), 64'd0);

      // log_clr alone empties the log; coincident with an error, the error is captured.
      idle(1'b1, 1'b0, 1'b1);
      checkOutput("log_cleared", 64'(log_valid), 64'd0);
      makeWord(2, d, e);
      sendWord(d, e, 32'h3000);
      idle(1'b1, 1'b0, 1'b0);
      idle(1'b1, 1'b0, 1'b1);
      checkOutput("log_clr_capture", 64'(log_valid), 64'd1);
      checkOutput("log_clr_addr", 64'(log_addr), 64'h3000);

      // Reset with two words in flight.
      sendWord(d0, e0, 32'h4000);
      sendWord(d0 ^ 64'h4, e0, 32'h4001);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      resetModel();
      checkState();
      @(posedge clk);
      #1;
      rst = 1'b0;
      sendWord(d0, e0, 32'h4100);
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("after_rst_data", data_out, d0);
      drain();

`ifdef ECC_ERR_INJECT_EN
      // Single-bit injection on a clean word is corrected and counted.
      applyStimulus(1'b1, d0, e0, 32'h5000, 72'd1 << 20, 1'b1, 1'b0, 1'b0, acc, rdy);
      idle(1'b1, 1'b0, 1'b0);
      checkOutput("inject_sbe", 64'(sbe_flag), 64'd1);
      checkOutput("inject_corrected", data_out, d0);
      drain();
      checkOutput("inject_counted", 64'(sbe_count), 64'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
